id_ex_pipe_reg: RTL and testbench

ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

---
 rtl/id_ex_pipe_reg_if.sv | 18 +
 rtl/id_ex_pipe_reg.sv | 151 +++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_pipe_reg_if.sv
// Valid/ready stream channel carrying one ID/EX entry (payload + control).
//   valid : entry present (master -> slave)
//   ready : entry accepted (slave -> master)
//   data  : DATA_W-bit decode payload
//   ctrl  : CTRL_W-bit control bits {regWrite, memWrite, memRead2}
// master drives valid/data/ctrl; slave drives ready.
interface id_ex_pipe_reg_if #(
    parameter int unsigned DATA_W = 288,
    parameter int unsigned CTRL_W = 3
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input ready);
    modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with optional skid slot, hazard bubble insertion,
// flush and a saturating bubble counter.
// Optional feature macro: ID_EX_SKID_EN (adds the skid register).
// Ports:
//   REG_CLOCK    : clock, all state on rising edge
//   REG_RESET_N  : asynchronous active-low reset
//   in_if        : upstream channel (IN_VALID/IN_READY/IN_DATA/IN_CTRL)
//   out_if       : downstream channel (OUT_VALID/OUT_READY/OUT_DATA/OUT_CTRL)
//   BUBBLE       : stall upstream and insert a NOP entry
//   FLUSH        : squash all held entries (highest priority)
//   OCCUPANCY    : number of held entries
//   BUBBLE_CNT   : saturating count of bubbles inserted since reset
module id_ex_pipe_reg #(
    parameter int unsigned DATA_W = 288,
    parameter int unsigned CTRL_W = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    REG_CLOCK,
    input  logic                    REG_RESET_N,
    id_ex_pipe_reg_if.slave         in_if,
    id_ex_pipe_reg_if.master        out_if,
    input  logic                    BUBBLE,
    input  logic                    FLUSH,
    output logic [1:0]              OCCUPANCY,
    output logic [CNT_W-1:0]        BUBBLE_CNT
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic              head_valid_q, head_valid_d;
    logic [DATA_W-1:0] head_data_q,  head_data_d;
    logic [CTRL_W-1:0] head_ctrl_q,  head_ctrl_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    // Low while in reset, so the stage never advertises ready during reset.
    logic              alive_q;

    logic in_ready_c;
    logic drain;
    logic head_free;
    logic accept;

`ifdef ID_EX_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;

    // Ready depends only on registered state, breaking the OUT_READY path.
    assign in_ready_c = alive_q & ~skid_valid_q & ~BUBBLE;
    assign OCCUPANCY  = 2'(head_valid_q) + 2'(skid_valid_q);
`else
    assign in_ready_c = alive_q & (~head_valid_q | out_if.ready) & ~BUBBLE;
    assign OCCUPANCY  = 2'(head_valid_q);
`endif

    assign drain     = head_valid_q & out_if.ready;
    assign head_free = ~head_valid_q | drain;
    assign accept    = in_if.valid & in_ready_c;

    assign in_if.ready  = in_ready_c;
    assign out_if.valid = head_valid_q;
    assign out_if.data  = head_data_q;
    assign out_if.ctrl  = head_ctrl_q;
    assign BUBBLE_CNT   = cnt_q;

    // Next-state: flush > skid promotion > head load (bubble/entry) > skid load.
    // Head payload is zeroed whenever head goes empty, keeping OUT_* zero when invalid.
    always_comb begin
        head_valid_d = head_valid_q;
        head_data_d  = head_data_q;
        head_ctrl_d  = head_ctrl_q;
        cnt_d        = cnt_q;
`ifdef ID_EX_SKID_EN
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;
`endif
        if (FLUSH) begin
            head_valid_d = 1'b0;
            head_data_d  = '0;
            head_ctrl_d  = '0;
`ifdef ID_EX_SKID_EN
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
            skid_ctrl_d  = '0;
`endif
        end
`ifdef ID_EX_SKID_EN
        else if (drain && skid_valid_q) begin
            head_valid_d = 1'b1;
            head_data_d  = skid_data_q;
            head_ctrl_d  = skid_ctrl_q;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
            skid_ctrl_d  = '0;
        end
`endif
        else if (head_free) begin
            if (BUBBLE) begin
                head_valid_d = 1'b1;
                head_data_d  = '0;
                head_ctrl_d  = '0;
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (accept) begin
                head_valid_d = 1'b1;
                head_data_d  = in_if.data;
                head_ctrl_d  = in_if.ctrl;
            end else begin
                head_valid_d = 1'b0;
                head_data_d  = '0;
                head_ctrl_d  = '0;
            end
        end
`ifdef ID_EX_SKID_EN
        else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_if.data;
            skid_ctrl_d  = in_if.ctrl;
        end
`endif
    end

    // State registers.
    always_ff @(posedge REG_CLOCK or negedge REG_RESET_N) begin
        if (!REG_RESET_N) begin
            alive_q      <= 1'b0;
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
            head_ctrl_q  <= '0;
            cnt_q        <= '0;
`ifdef ID_EX_SKID_EN
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
`endif
        end else begin
            alive_q      <= 1'b1;
            head_valid_q <= head_valid_d;
            head_data_q  <= head_data_d;
            head_ctrl_q  <= head_ctrl_d;
            cnt_q        <= cnt_d;
`ifdef ID_EX_SKID_EN
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
`endif
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: directed stimulus pushes expected
// entries, a negedge monitor pops and compares every drained entry.
// A second instance with CNT_W=2 shares all inputs to check counter saturation.
module tb_id_ex_pipe_reg;

    localparam int unsigned DATA_W = 288;
    localparam int unsigned CTRL_W = 3;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned EW     = DATA_W + CTRL_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             bubble;
    logic             flush;
    logic [1:0]       occ, sat_occ;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       sat_cnt;

    id_ex_pipe_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) in_if ();
    id_ex_pipe_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) out_if ();
    id_ex_pipe_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) sin_if ();
    id_ex_pipe_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) sout_if ();

    assign sin_if.valid  = in_if.valid;
    assign sin_if.data   = in_if.data;
    assign sin_if.ctrl   = in_if.ctrl;
    assign sout_if.ready = out_if.ready;

    id_ex_pipe_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .REG_CLOCK   (clk),
        .REG_RESET_N (rst_n),
        .in_if       (in_if),
        .out_if      (out_if),
        .BUBBLE      (bubble),
        .FLUSH       (flush),
        .OCCUPANCY   (occ),
        .BUBBLE_CNT  (cnt)
    );

    id_ex_pipe_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(2)) dut_sat (
        .REG_CLOCK   (clk),
        .REG_RESET_N (rst_n),
        .in_if       (sin_if),
        .out_if      (sout_if),
        .BUBBLE      (bubble),
        .FLUSH       (flush),
        .OCCUPANCY   (sat_occ),
        .BUBBLE_CNT  (sat_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;
    logic [EW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [319:0] got, input logic [319:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(input int k);
        if (k < 16) return DATA_W'(k);
        return {9{32'(k)}};
    endfunction

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    // One cycle: apply inputs, optionally push expectation, check IN_READY, clock.
    // push: 0 none, 1 the input entry, 2 a bubble entry. exp_rdy < 0 skips the check.
    task automatic cyc(input logic v, input int k, input logic [2:0] c, input logic bub,
                       input logic fl, input logic ordy, input int exp_rdy, input int push);
        in_if.valid  = v;
        in_if.data   = pat(k);
        in_if.ctrl   = c;
        bubble       = bub;
        flush        = fl;
        out_if.ready = ordy;
        if (push == 1) exp_q.push_back({c, pat(k)});
        if (push == 2) exp_q.push_back('0);
        #1;
        if (exp_rdy >= 0) chk("in_ready", 320'(in_if.ready), 320'(exp_rdy));
        @(posedge clk);
        if (fl) exp_q.delete();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 3'b000, 1'b0, 1'b0, 1'b1, -1, 0);
    endtask

    // Monitor: compare drained entries, check hold-stability and zero-when-invalid.
    logic          held = 1'b0;
    logic [EW-1:0] held_v;
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (out_if.valid) begin
            if (held) chk("hold", 320'({out_if.ctrl, out_if.data}), 320'(held_v));
            if (out_if.ready) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 320'({out_if.ctrl, out_if.data}), 320'h0);
                    fails += (tests > 0 && {out_if.ctrl, out_if.data} == '0) ? 1 : 0;
                end else begin
                    e = exp_q.pop_front();
                    chk("out_entry", 320'({out_if.ctrl, out_if.data}), 320'(e));
                end
            end else begin
                held   = 1'b1;
                held_v = {out_if.ctrl, out_if.data};
            end
        end else begin
            held = 1'b0;
            chk("zero_when_invalid", 320'({out_if.ctrl, out_if.data}), 320'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        in_if.ctrl   = '0;
        bubble       = 1'b0;
        flush        = 1'b0;
        out_if.ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 320'(out_if.valid), 320'h0);
        chk("rst_out_data", 320'(out_if.data), 320'h0);
        chk("rst_occ", 320'(occ), 320'h0);
        chk("rst_cnt", 320'(cnt), 320'h0);
        chk("rst_in_ready", 320'(in_if.ready), 320'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 320'(in_if.ready), 320'h1);

        // Back-to-back stream 0..9
        for (int k = 0; k < 10; k++) cyc(1'b1, k, 3'b101, 1'b0, 1'b0, 1'b1, 1, 1);
        idle(1);
        chk("stream_drained", 320'(exp_q.size()), 320'h0);

`ifdef ID_EX_SKID_EN
        // Skid: A held, B into skid, then both drain on consecutive cycles
        cyc(1'b1, 16'hA0, 3'b100, 1'b0, 1'b0, 1'b0, 1, 1);
        cyc(1'b1, 16'hB0, 3'b010, 1'b0, 1'b0, 1'b0, 1, 1);
        chk("skid_occ2", 320'(occ), 320'h2);
        cyc(1'b1, 16'hC0, 3'b001, 1'b0, 1'b0, 1'b0, 0, 0);
        cyc(1'b0, 0, 3'b000, 1'b0, 1'b0, 1'b1, 0, 0);
        cyc(1'b0, 0, 3'b000, 1'b0, 1'b0, 1'b1, 1, 0);
        chk("skid_drained", 320'(exp_q.size()), 320'h0);
        chk("skid_occ0", 320'(occ), 320'h0);
`else
        // Stall: A held, B refused, then B accepted as A drains
        cyc(1'b1, 16'hA0, 3'b100, 1'b0, 1'b0, 1'b0, 1, 1);
        cyc(1'b1, 16'hB0, 3'b010, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("stall_occ1", 320'(occ), 320'h1);
        cyc(1'b1, 16'hB0, 3'b010, 1'b0, 1'b0, 1'b1, 1, 1);
        cyc(1'b0, 0, 3'b000, 1'b0, 1'b0, 1'b1, 1, 0);
        chk("stall_drained", 320'(exp_q.size()), 320'h0);
`endif

        // Bubble x2 with held input D accepted afterwards
        cyc(1'b1, 16'hD0, 3'b110, 1'b1, 1'b0, 1'b1, 0, 2); exp_cnt++;
        cyc(1'b1, 16'hD0, 3'b110, 1'b1, 1'b0, 1'b1, 0, 2); exp_cnt++;
        chk("bubble_cnt2", 320'(cnt), 320'(exp_cnt));
        cyc(1'b1, 16'hD0, 3'b110, 1'b0, 1'b0, 1'b1, 1, 1);
        idle(1);
        chk("bubble_drained", 320'(exp_q.size()), 320'h0);

        // Flush with full stage, IN_VALID and BUBBLE asserted
        cyc(1'b1, 16'hE0, 3'b011, 1'b0, 1'b0, 1'b0, 1, 1);
`ifdef ID_EX_SKID_EN
        cyc(1'b1, 16'hF0, 3'b010, 1'b0, 1'b0, 1'b0, 1, 1);
        chk("flush_pre_occ", 320'(occ), 320'h2);
`else
        cyc(1'b1, 16'hF0, 3'b010, 1'b0, 1'b0, 1'b0, 0, 0);
        chk("flush_pre_occ", 320'(occ), 320'h1);
`endif
        cyc(1'b1, 16'hF1, 3'b111, 1'b1, 1'b1, 1'b0, 0, 0);
        chk("flush_out_valid", 320'(out_if.valid), 320'h0);
        chk("flush_occ", 320'(occ), 320'h0);
        chk("flush_cnt", 320'(cnt), 320'(exp_cnt));
        // Flush does not gate IN_READY; the accepted entry is dropped
        cyc(1'b1, 16'hF2, 3'b101, 1'b0, 1'b1, 1'b1, 1, 1);
        chk("flush_drop_valid", 320'(out_if.valid), 320'h0);
        chk("flush_drop_occ", 320'(occ), 320'h0);

        // Reset mid-stream with head full
        cyc(1'b1, 300, 3'b110, 1'b0, 1'b0, 1'b0, 1, 1);
        in_if.valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 320'(out_if.valid), 320'h0);
        chk("mid_rst_out_data", 320'({out_if.ctrl, out_if.data}), 320'h0);
        chk("mid_rst_occ", 320'(occ), 320'h0);
        chk("mid_rst_cnt", 320'(cnt), 320'h0);
        chk("mid_rst_sat_cnt", 320'(sat_cnt), 320'h0);
        chk("mid_rst_in_ready", 320'(in_if.ready), 320'h0);
        exp_q.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_release_ready", 320'(in_if.ready), 320'h1);
        cyc(1'b1, 301, 3'b101, 1'b0, 1'b0, 1'b1, 1, 1);
        idle(1);
        chk("mid_rst_drained", 320'(exp_q.size()), 320'h0);

        // Saturation: 5 bubbles, CNT_W=2 copy stops at 3
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 0, 3'b000, 1'b1, 1'b0, 1'b1, 0, 2);
            exp_cnt++;
            chk("sat_main_cnt", 320'(cnt), 320'(exp_cnt));
            chk("sat_small_cnt", 320'(sat_cnt), 320'(sat3(exp_cnt)));
        end
        idle(2);
        chk("final_drained", 320'(exp_q.size()), 320'h0);
        chk("final_occ", 320'(occ), 320'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
